grid_loader: RTL

- Downstream of the pattern selector. On a load request, scans every cell of the Life grid in row-major order.
- Presents each coordinate to the pattern ROMs and the selector, then writes the returned selected pattern bit into the cell-grid RAM.
- Holds the generation engine off while loading.
- Latches the user's 2-bit pattern choice at load start so that switch motion mid-load cannot corrupt the seed.

---
 rtl/gol_pkg.sv | 10 +
 rtl/xy_scan_counter.sv | 29 ++
 rtl/grid_loader.sv | 92 +++++++++
 3 files changed

// File: rtl/gol_pkg.sv
// gol_pkg: shared Life grid defaults, loader states and pattern codes
package gol_pkg;
  localparam int GRID_W_DEF = 32;
  localparam int GRID_H_DEF = 32;
  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} ld_state_e;
  localparam logic [1:0] GLIDER  = 2'b00;
  localparam logic [1:0] BLINKER = 2'b01;
  localparam logic [1:0] BEACON  = 2'b10;
  localparam logic [1:0] ACORN   = 2'b11;
endpackage

// File: rtl/xy_scan_counter.sv
// xy_scan_counter: row-major x/y counter with clear, enable and last-cell flag
module xy_scan_counter #(
  parameter int W = 32,
  parameter int H = 32,
  parameter int XW = $clog2(W),
  parameter int YW = $clog2(H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          last_o
);
  logic last_x, last_y;
  assign last_x = x_o == XW'(W - 1);
  assign last_y = y_o == YW'(H - 1);
  assign last_o = last_x && last_y;
  // explicit compares so non-power-of-2 sizes wrap correctly
  always_ff @(posedge clk)
    if (rst || clr_i) begin
      x_o <= '0;
      y_o <= '0;
    end else if (en_i) begin
      x_o <= last_x ? '0 : x_o + 1'b1;
      y_o <= last_x ? (last_y ? '0 : y_o + 1'b1) : y_o;
    end
endmodule

// File: rtl/grid_loader.sv
// grid_loader: seeds the Life grid RAM from the selected pattern ROM on request
// Optional GRID_LOADER_AUTORELOAD_EN: debounced switch change triggers a reload.
module grid_loader
  import gol_pkg::*;
#(
  parameter int GRID_W = GRID_W_DEF,
  parameter int GRID_H = GRID_H_DEF,
  parameter int ADDR_W = $clog2(GRID_W * GRID_H)
`ifdef GRID_LOADER_AUTORELOAD_EN
  , parameter int DEB_CYC = 65536
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_req,
  input  logic [1:0]                sel_sw,
  input  logic                      pat_bit,
  output logic [1:0]                sel_q,
  output logic [$clog2(GRID_W)-1:0] cell_x,
  output logic [$clog2(GRID_H)-1:0] cell_y,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic                      wr_data,
  output logic                      busy,
  output logic                      done
);
  ld_state_e   state_q;
  logic        start, last;
  logic [1:0]  sel_src;
  logic [31:0] lin;
  assign lin = 32'(cell_y) * 32'(GRID_W) + 32'(cell_x);
  assign wr_data = wr_en & pat_bit;
`ifdef GRID_LOADER_AUTORELOAD_EN
  localparam int CW = $clog2(DEB_CYC + 1);
  logic [1:0]    s1_q, s2_q;
  logic [CW-1:0] cnt_q;
  logic          stable_diff;
  assign stable_diff = state_q == IDLE && s1_q == s2_q && s2_q != sel_q;
  always_ff @(posedge clk)
    if (rst) begin
      s1_q  <= '0;
      s2_q  <= '0;
      cnt_q <= '0;
    end else begin
      s1_q  <= sel_sw;
      s2_q  <= s1_q;
      cnt_q <= stable_diff ? cnt_q + 1'b1 : '0;
    end
  assign start   = load_req | (stable_diff && cnt_q == CW'(DEB_CYC - 1));
  assign sel_src = s2_q;
`else
  assign start   = load_req;
  assign sel_src = sel_sw;
`endif
  xy_scan_counter #(.W(GRID_W), .H(GRID_H)) u_scan (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_q == IDLE && start),
    .en_i   (state_q == SCAN && !last),
    .x_o    (cell_x),
    .y_o    (cell_y),
    .last_o (last)
  );
  // write lags the presented coordinate by one cycle to match ROM latency
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done    <= 1'b0;
      wr_en   <= state_q == SCAN;
      wr_addr <= state_q == SCAN ? lin[ADDR_W-1:0] : wr_addr;
      case (state_q)
        IDLE: if (start) begin
          sel_q   <= sel_src;
          busy    <= 1'b1;
          state_q <= SCAN;
        end
        SCAN: state_q <= last ? FLUSH : SCAN;
        FLUSH: begin
          busy    <= 1'b0;
          done    <= 1'b1;
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule
